// File: rtl/rx_descrambler_sync_if.sv
// rtl/rx_descrambler_sync_if.sv - block stream between gearbox, descrambler and block decoder
interface rx_descrambler_sync_if #(
  parameter int RX_DATA_WIDTH = 64
);
  logic [RX_DATA_WIDTH+1:0] data_in;
  logic                     data_valid;
  logic [RX_DATA_WIDTH-1:0] data_out;
  logic [1:0]               header_out;
  logic                     valid_out;
  logic                     block_lock;
  logic                     bitslip;

  modport master (
    output data_in, data_valid,
    input  data_out, header_out, valid_out, block_lock, bitslip
  );

  modport slave (
    input  data_in, data_valid,
    output data_out, header_out, valid_out, block_lock, bitslip
  );
endinterface

// File: rtl/rx_descrambler_sync.sv
// rtl/rx_descrambler_sync.sv - 64b/66b sync header lock FSM and x^58+x^39+1 descrambler
// Build option: DESCRAMBLER_EN enables descrambling; undefined passes the payload through.
module rx_descrambler_sync #(
  parameter int RX_DATA_WIDTH = 64,
  parameter int LOCK_COUNT    = 64,
  parameter int WINDOW        = 64,
  parameter int ERR_LIMIT     = 16,
  parameter int SLIP_WAIT     = 32
) (
  input  logic               clk,
  input  logic               rst,
  rx_descrambler_sync_if.slave bus
);
  localparam int W  = RX_DATA_WIDTH;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int NW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [NW-1:0] WIN_END   = NW'(WINDOW);
  localparam logic [EW-1:0] ERR_END   = EW'(ERR_LIMIT);
  localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_WAIT - 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SLIP   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [GW-1:0] r_good_cnt, w_good_nxt;
  logic [NW-1:0] r_win_cnt, w_win_nxt, w_win_inc;
  logic [EW-1:0] r_err_cnt, w_err_nxt, w_err_inc;
  logic [SW-1:0] r_slip_cnt, w_slip_nxt;
  logic          r_lock, w_lock_nxt;
  logic          r_bitslip, w_bitslip_nxt;
  logic          r_valid_out;
  logic [W-1:0]  r_data_out;
  logic [1:0]    r_header_out;

  logic [1:0]    w_hdr;
  logic          w_hdr_ok;
  logic [W-1:0]  w_payload;

  assign w_hdr    = bus.data_in[W+1:W];
  assign w_hdr_ok = w_hdr[1] ^ w_hdr[0];

`ifdef DESCRAMBLER_EN
  logic [57:0] r_hist;
  logic [57:0] w_hist;

  // Serial descramble unrolled over the block; scrambled bits feed the history.
  always_comb begin
    w_hist    = r_hist;
    w_payload = '0;
    for (int i = 0; i < W; i++) begin
      w_payload[i] = bus.data_in[i] ^ w_hist[38] ^ w_hist[57];
      w_hist       = {w_hist[56:0], bus.data_in[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '1;
    end else if (bus.data_valid) begin
      r_hist <= w_hist;
    end
  end
`else
  assign w_payload = bus.data_in[W-1:0];
`endif

  assign w_win_inc = r_win_cnt + NW'(1);
  assign w_err_inc = r_err_cnt + EW'(!w_hdr_ok);

  always_comb begin
    w_state_nxt   = r_state;
    w_good_nxt    = r_good_cnt;
    w_win_nxt     = r_win_cnt;
    w_err_nxt     = r_err_cnt;
    w_slip_nxt    = r_slip_cnt;
    w_lock_nxt    = r_lock;
    w_bitslip_nxt = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (bus.data_valid) begin
          if (!w_hdr_ok) begin
            w_bitslip_nxt = 1'b1;
            w_good_nxt    = '0;
            w_slip_nxt    = '0;
            w_state_nxt   = ST_SLIP;
          end else if (r_good_cnt == GOOD_LAST) begin
            w_lock_nxt  = 1'b1;
            w_good_nxt  = '0;
            w_win_nxt   = '0;
            w_err_nxt   = '0;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_good_nxt = r_good_cnt + GW'(1);
          end
        end
      end
      // Counts clocks, not blocks, so the gearbox has time to settle.
      ST_SLIP: begin
        if (r_slip_cnt == SLIP_LAST) begin
          w_slip_nxt  = '0;
          w_state_nxt = ST_HUNT;
        end else begin
          w_slip_nxt = r_slip_cnt + SW'(1);
        end
      end
      ST_LOCKED: begin
        if (bus.data_valid) begin
          if (w_err_inc == ERR_END) begin
            w_lock_nxt    = 1'b0;
            w_bitslip_nxt = 1'b1;
            w_win_nxt     = '0;
            w_err_nxt     = '0;
            w_slip_nxt    = '0;
            w_state_nxt   = ST_SLIP;
          end else if (w_win_inc == WIN_END) begin
            w_win_nxt = '0;
            w_err_nxt = '0;
          end else begin
            w_win_nxt = w_win_inc;
            w_err_nxt = w_err_inc;
          end
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_good_cnt <= '0;
      r_win_cnt  <= '0;
      r_err_cnt  <= '0;
      r_slip_cnt <= '0;
      r_lock     <= 1'b0;
      r_bitslip  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_win_cnt  <= w_win_nxt;
      r_err_cnt  <= w_err_nxt;
      r_slip_cnt <= w_slip_nxt;
      r_lock     <= w_lock_nxt;
      r_bitslip  <= w_bitslip_nxt;
    end
  end

  // Gating with the post-update lock makes the locking block the first output
  // and suppresses the block that drops lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_out  <= 1'b0;
      r_data_out   <= '0;
      r_header_out <= 2'b00;
    end else begin
      r_valid_out <= bus.data_valid & w_lock_nxt;
      if (bus.data_valid) begin
        r_data_out   <= w_payload;
        r_header_out <= w_hdr;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.header_out = r_header_out;
  assign bus.valid_out  = r_valid_out;
  assign bus.block_lock = r_lock;
  assign bus.bitslip    = r_bitslip;
endmodule

// File: tb/tb_rx_descrambler_sync.sv
// tb/tb_rx_descrambler_sync.sv - directed bench for lock acquisition, slip, loss of lock and datapath
module tb_rx_descrambler_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rx_descrambler_sync_if #(.RX_DATA_WIDTH(64)) bus ();

  rx_descrambler_sync dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] pay;
    logic        v;
    logic        exp_vo;
    logic        exp_lock;
  } vec_t;

  vec_t tbl[8];

`ifdef DESCRAMBLER_EN
  logic [57:0] tx_h = '1;

  task automatic scramble(input logic [63:0] p, output logic [63:0] s);
    for (int i = 0; i < 64; i++) begin
      s[i] = p[i] ^ tx_h[38] ^ tx_h[57];
      tx_h = {tx_h[56:0], s[i]};
    end
  endtask
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic blk(input logic [1:0] h, input logic [63:0] p, input logic v);
    logic [63:0] s;
    s = p;
`ifdef DESCRAMBLER_EN
    if (v) scramble(p, s);
`endif
    bus.data_in    = {h, s};
    bus.data_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef DESCRAMBLER_EN
    tx_h = '1;
`endif
  endtask

  task automatic acquire(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      blk(2'b01, {32'(i), 32'hC0FFEE00}, 1'b1);
      if (bus.block_lock !== 1'b0 || bus.valid_out !== 1'b0 || bus.bitslip !== 1'b0) bad++;
    end
    chk({nm, "_early"}, 64'(bad), 64'd0);
    blk(2'b10, 64'h1122334455667788, 1'b1);
    chk({nm, "_lock"}, 64'(bus.block_lock), 64'd1);
    chk({nm, "_vo"}, 64'(bus.valid_out), 64'd1);
    chk({nm, "_bitslip"}, 64'(bus.bitslip), 64'd0);
    chk({nm, "_data"}, bus.data_out, 64'h1122334455667788);
    chk({nm, "_hdr"}, 64'(bus.header_out), 64'd2);
  endtask

  initial begin
    int bad;
    int slips;

    tbl[0] = '{2'b01, 64'hDEADBEEF01234567, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{2'b10, 64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{2'b01, 64'h5555555555555555, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{2'b00, 64'hFFFF0000FFFF0000, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{2'b01, 64'h0000000000000000, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{2'b11, 64'hA5A5A5A5A5A5A5A5, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{2'b11, 64'h1111111111111111, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{2'b01, 64'h5A5A5A5A5A5A5A5A, 1'b1, 1'b1, 1'b1};

    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", bus.data_out, 64'd0);
    chk("rst_header_out", 64'(bus.header_out), 64'd0);
    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_block_lock", 64'(bus.block_lock), 64'd0);
    chk("rst_bitslip", 64'(bus.bitslip), 64'd0);
    rst = 1'b0;

    acquire("acq");

    for (int i = 0; i < 8; i++) begin
      blk(tbl[i].hdr, tbl[i].pay, tbl[i].v);
      chk($sformatf("tbl%0d_vo", i), 64'(bus.valid_out), 64'(tbl[i].exp_vo));
      chk($sformatf("tbl%0d_lock", i), 64'(bus.block_lock), 64'(tbl[i].exp_lock));
      chk($sformatf("tbl%0d_bitslip", i), 64'(bus.bitslip), 64'd0);
      if (tbl[i].exp_vo) begin
        chk($sformatf("tbl%0d_data", i), bus.data_out, tbl[i].pay);
        chk($sformatf("tbl%0d_hdr", i), 64'(bus.header_out), 64'(tbl[i].hdr));
      end
    end

    bad = 0;
    for (int i = 0; i < 4; i++) begin
      blk(2'b01, 64'h0, 1'b1);
      if (bus.data_out !== 64'h0 || bus.valid_out !== 1'b1) bad++;
    end
    chk("zero_payload", 64'(bad), 64'd0);

`ifdef DESCRAMBLER_EN
    begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      tx_h = r[57:0];
      blk(2'b01, 64'h0F0F0F0F0F0F0F0F, 1'b1);
      blk(2'b10, 64'hCAFEF00D12345678, 1'b1);
      chk("rand_seed_second", bus.data_out, 64'hCAFEF00D12345678);
    end
`endif

    do_reset();
    for (int i = 0; i < 10; i++) blk(2'b01, 64'(i), 1'b1);
    blk(2'b11, 64'hBAD0BAD0BAD0BAD0, 1'b1);
    chk("slip_pulse", 64'(bus.bitslip), 64'd1);
    chk("slip_lock", 64'(bus.block_lock), 64'd0);
    chk("slip_vo", 64'(bus.valid_out), 64'd0);
    slips = 0;
    for (int i = 0; i < 32; i++) begin
      blk((i % 3 == 0) ? 2'b00 : 2'b11, 64'(i), (i % 2) == 0);
      if (bus.bitslip !== 1'b0 || bus.block_lock !== 1'b0) slips++;
    end
    chk("slip_wait_ignored", 64'(slips), 64'd0);
    acquire("reacq");

    bad   = 0;
    slips = 0;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 64; b++) begin
        blk((b < 15) ? 2'b00 : 2'b01, 64'(b), 1'b1);
        if (bus.block_lock !== 1'b1 || bus.valid_out !== 1'b1) bad++;
        if (bus.bitslip !== 1'b0) slips++;
      end
    end
    chk("window_hold_lock", 64'(bad), 64'd0);
    chk("window_no_slip", 64'(slips), 64'd0);

    bad = 0;
    for (int i = 0; i < 15; i++) begin
      blk(2'b00, 64'(i), 1'b1);
      if (bus.block_lock !== 1'b1 || bus.valid_out !== 1'b1 || bus.bitslip !== 1'b0) bad++;
    end
    chk("loss_pre16", 64'(bad), 64'd0);
    blk(2'b00, 64'hEEEE, 1'b1);
    chk("loss_lock", 64'(bus.block_lock), 64'd0);
    chk("loss_bitslip", 64'(bus.bitslip), 64'd1);
    chk("loss_vo", 64'(bus.valid_out), 64'd0);
    blk(2'b01, 64'h1, 1'b0);
    chk("loss_bitslip_one_cycle", 64'(bus.bitslip), 64'd0);

    do_reset();
    acquire("pre_rst");
    blk(2'b01, 64'hDEADBEEF01234567, 1'b1);
    chk("bypass_data", bus.data_out, 64'hDEADBEEF01234567);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_lock", 64'(bus.block_lock), 64'd0);
    chk("async_rst_vo", 64'(bus.valid_out), 64'd0);
    chk("async_rst_data", bus.data_out, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef DESCRAMBLER_EN
    tx_h = '1;
`endif
    blk(2'b01, 64'h2, 1'b1);
    chk("post_rst_no_lock", 64'(bus.block_lock), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_descrambler_sync.md
# rx_descrambler_sync

Receive-side counterpart of the 64b/66b transmit scrambler: it takes 66-bit blocks from the RX gearbox, qualifies the 2-bit sync header, and acquires and monitors block lock with a hunt/slip/locked state machine. It removes the x^58+x^39+1 self-synchronising scrambling from the 64-bit payload. It sits between the gearbox, which it drives with a bitslip request, and the block decoder.

## Interface
- RX_DATA_WIDTH, 64, payload bits per block (header excluded)
- LOCK_COUNT, 64, consecutive valid headers needed to declare lock
- WINDOW, 64, headers per error-monitoring window while locked
- ERR_LIMIT, 16, invalid headers within one window that drop lock
- SLIP_WAIT, 32, clocks to ignore input after a bitslip request

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- data_in  in  RX_DATA_WIDTH+2  block from gearbox; [RX_DATA_WIDTH+1:RX_DATA_WIDTH] = sync header, [RX_DATA_WIDTH-1:0] = payload, payload bit 0 is first on the wire
- data_valid  in  1  data_in holds a new block this cycle
- data_out  out  RX_DATA_WIDTH  descrambled payload, same bit order as input
- header_out  out  2  sync header registered with data_out
- valid_out  out  1  data_out/header_out valid; asserted only while locked
- block_lock  out  1  block lock achieved
- bitslip  out  1  one-cycle request to the gearbox to shift alignment by one bit

## Operation
- A header is valid if it is 2'b01 or 2'b10. Headers 2'b00 and 2'b11 are invalid.
- Descrambler:
  - 58-bit history register; reset value all ones.
  - For i = 0..RX_DATA_WIDTH-1 in order: out[i] = in[i] ^ h[38] ^ h[57]. After each bit, h shifts left and the received scrambled in[i] enters at h[0].
  - History advances only on data_valid, and in every FSM state. It is self-synchronising, so it is never reloaded on a lock change.
- FSM states: HUNT, SLIP_WAIT, LOCKED. Reset state is HUNT with all counters 0.
- HUNT:
  - Each valid block with a valid header increments good_cnt.
  - When good_cnt reaches LOCK_COUNT: go to LOCKED, block_lock=1, clear counters.
  - Any invalid header: pulse bitslip, clear good_cnt, go to SLIP_WAIT.
- SLIP_WAIT:
  - Counts clocks (not blocks) up to SLIP_WAIT, ignoring headers, then returns to HUNT.
  - bitslip is never asserted in this state.
- LOCKED:
  - win_cnt counts valid blocks; err_cnt counts invalid headers.
  - The current block's header is counted before the comparisons below.
  - If err_cnt reaches ERR_LIMIT: block_lock=0, pulse bitslip, clear counters, go to SLIP_WAIT. This takes priority over window end.
  - Else if win_cnt reaches WINDOW: clear both counters and stay LOCKED.
- Counter widths are sized from the parameters (clog2 of value+1). Counters never wrap.
- No back-pressure: the downstream decoder must accept every valid_out cycle.

## Timing
- Reset values:
  - data_out = 0, header_out = 0, valid_out = 0
  - block_lock = 0, bitslip = 0, history all ones
- Datapath latency: 1 clock from data_valid to valid_out.
- valid_out = registered data_valid AND block_lock as it stands after that block's update. The block that completes lock is the first output block.
- The block that causes loss of lock is not output.
- bitslip is high for exactly one clock, in the cycle after the offending block is sampled.
- If data_valid is low, no counter changes, with one exception: the SLIP_WAIT clock counter keeps running.
- rst mid-operation immediately forces all reset values, including history, regardless of state.

## Configuration
- DESCRAMBLER_EN defined: payload is descrambled as described above.
- DESCRAMBLER_EN undefined:
  - data_out = registered payload, unmodified, matching a transmitter built with scrambling skipped.
  - The history register and XOR logic are removed.
  - Lock FSM, latency and all other outputs are identical.

## Test plan
- Lock acquisition: after rst, 64 blocks with header 2'b01 -> block_lock rises after block 64. valid_out first asserts for block 64. bitslip never asserted.
- Slip on bad header: in HUNT, 10 good headers then 2'b11 -> one-cycle bitslip. The next 32 clocks of input are ignored. HUNT then restarts from good_cnt=0.
- Loss of lock: while locked, 16 headers of 2'b00 within one 64-block window -> block_lock falls on the 16th, bitslip pulses, valid_out stays low for that block.
- Window reset: while locked, 15 bad headers per window over 4 windows -> block_lock held at 1 throughout.
- Descrambler round trip (DESCRAMBLER_EN): an all-zero payload is scrambled by a reference model seeded all ones; after lock, data_out = 64'h0 for every block. Seeding the model with a random state gives a correct output from the second block on.
- Bypass (no DESCRAMBLER_EN): payload 64'hDEADBEEF_01234567 -> data_out identical one clock later; rst asserted mid-lock clears block_lock and valid_out asynchronously.
